// File: rtl/pwm_peripheral.sv
// 16-channel PWM driver: a shared prescaled 8-bit counter compared against one duty value.
// Define PWM_SHADOW_EN to latch the duty once per period so updates land on period_start.
module pwm_peripheral #(
    parameter int CLK_DIV = 3000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    logic [15:0] r_div_cnt;
    logic [7:0]  r_pwm_counter;
    logic [7:0]  w_duty_active;
    logic        w_tick;
    logic        w_wrap;
    logic        w_pwm_level;
    logic [15:0] w_en_out;
    logic [15:0] w_en_pwm;
    logic [15:0] w_out_next;

    assign w_tick = (r_div_cnt == DIV_LAST);
    assign w_wrap = w_tick && (r_pwm_counter == 8'hFF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt     <= '0;
            r_pwm_counter <= '0;
        end else if (w_tick) begin
            r_div_cnt     <= '0;
            r_pwm_counter <= r_pwm_counter + 8'd1;
        end else begin
            r_div_cnt     <= r_div_cnt + 16'd1;
        end
    end

`ifdef PWM_SHADOW_EN
    logic [7:0] r_duty_shadow;

    // Loaded on the wrap tick so the new duty is first compared against counter value 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_duty_shadow <= '0;
        end else if (w_wrap) begin
            r_duty_shadow <= pwm_duty_cycle;
        end
    end

    assign w_duty_active = r_duty_shadow;
`else
    assign w_duty_active = pwm_duty_cycle;
`endif

    // 0xFF is special-cased to a solid high rather than 255/256.
    assign w_pwm_level = (w_duty_active == 8'hFF) || (r_pwm_counter < w_duty_active);

    assign w_en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign w_en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    always_comb begin
        w_out_next = w_en_out & (~w_en_pwm | {16{w_pwm_level}});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out          <= '0;
            period_start <= 1'b0;
        end else begin
            out          <= w_out_next;
            period_start <= w_wrap;
        end
    end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Scoreboard bench for pwm_peripheral: three instances (CLK_DIV 4, 2, 1) share stimulus;
// expectations are keyed by clock count since reset release and checked on the falling edge.
module tb_pwm_peripheral;

    typedef struct {
        int          cyc;
        logic [15:0] o;
        logic        p;
        int          tag;
    } chk_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] en_out = '0;
    logic [15:0] en_pwm = '0;
    logic [7:0]  duty = '0;
    logic [15:0] w_out [3];
    logic        w_ps  [3];

    int     cyc = 0;
    int     n_assert = 0;
    int     n_fail = 0;
    chk_t   sb [3][$];
    string  names [$];

    always #5 clk = ~clk;

    pwm_peripheral #(.CLK_DIV(4)) u_dut_div4 (
        .clk(clk), .rst_n(rst_n),
        .en_reg_out_7_0(en_out[7:0]), .en_reg_out_15_8(en_out[15:8]),
        .en_reg_pwm_7_0(en_pwm[7:0]), .en_reg_pwm_15_8(en_pwm[15:8]),
        .pwm_duty_cycle(duty), .out(w_out[0]), .period_start(w_ps[0])
    );

    pwm_peripheral #(.CLK_DIV(2)) u_dut_div2 (
        .clk(clk), .rst_n(rst_n),
        .en_reg_out_7_0(en_out[7:0]), .en_reg_out_15_8(en_out[15:8]),
        .en_reg_pwm_7_0(en_pwm[7:0]), .en_reg_pwm_15_8(en_pwm[15:8]),
        .pwm_duty_cycle(duty), .out(w_out[1]), .period_start(w_ps[1])
    );

    pwm_peripheral #(.CLK_DIV(1)) u_dut_div1 (
        .clk(clk), .rst_n(rst_n),
        .en_reg_out_7_0(en_out[7:0]), .en_reg_out_15_8(en_out[15:8]),
        .en_reg_pwm_7_0(en_pwm[7:0]), .en_reg_pwm_15_8(en_pwm[15:8]),
        .pwm_duty_cycle(duty), .out(w_out[2]), .period_start(w_ps[2])
    );

    // cyc == k means k rising edges have occurred since reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        chk_t e;
        for (int s = 0; s < 3; s++) begin
            while (sb[s].size() > 0 && sb[s][0].cyc < cyc) begin
                e = sb[s].pop_front();
                n_assert++;
                n_fail++;
                $display("FAIL %s: dut%0d check for cyc %0d never sampled (now cyc %0d)",
                         names[e.tag], s, e.cyc, cyc);
            end
            if (sb[s].size() > 0 && sb[s][0].cyc == cyc) begin
                e = sb[s].pop_front();
                n_assert++;
                if ({w_out[s], w_ps[s]} !== {e.o, e.p}) begin
                    n_fail++;
                    $display("FAIL %s: dut%0d cyc %0d got out=%h period_start=%b, expected out=%h period_start=%b",
                             names[e.tag], s, cyc, w_out[s], w_ps[s], e.o, e.p);
                end
            end
        end
    end

    task automatic push(input int s, input int c, input logic [15:0] o, input logic p,
                        input string n);
        chk_t e;
        e.cyc = c;
        e.o   = o;
        e.p   = p;
        e.tag = names.size();
        names.push_back(n);
        sb[s].push_back(e);
    endtask

    task automatic rst_on();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
    endtask

    task automatic rst_off();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_cyc(input int t);
        for (int i = 0; i < 4000 && cyc < t; i++) @(negedge clk);
        #1;
    endtask

    initial begin
        // Reset held with every input at 0xFF
        en_out = 16'hFFFF;
        en_pwm = 16'hFFFF;
        duty   = 8'hFF;
        for (int s = 0; s < 3; s++) push(s, 0, 16'h0000, 1'b0, "rst_hold");
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            n_assert++;
            if ({w_out[s], w_ps[s]} !== 17'h0) begin
                n_fail++;
                $display("FAIL rst_hold_direct: dut%0d out=%h period_start=%b during reset",
                         s, w_out[s], w_ps[s]);
            end
        end
        en_pwm = 16'h0000;
        push(0, 1,   16'hFFFF, 1'b0, "static_first");
        push(0, 100, 16'hFFFF, 1'b0, "static_run");
        push(2, 100, 16'hFFFF, 1'b0, "static_run");
        rst_n = 1'b1;
        wait_cyc(300);

        // Asynchronous reset mid-period, then counters restart from zero
        rst_on();
        #1;
        for (int s = 0; s < 3; s++) begin
            n_assert++;
            if ({w_out[s], w_ps[s]} !== 17'h0) begin
                n_fail++;
                $display("FAIL rst_async_direct: dut%0d out=%h period_start=%b not cleared asynchronously",
                         s, w_out[s], w_ps[s]);
            end
        end
        for (int s = 0; s < 3; s++) push(s, 0, 16'h0000, 1'b0, "rst_async");
        push(0, 1023, 16'hFFFF, 1'b0, "restart_pre");
        push(0, 1024, 16'hFFFF, 1'b1, "restart_ps");
        push(1, 511,  16'hFFFF, 1'b0, "restart_pre");
        push(1, 512,  16'hFFFF, 1'b1, "restart_ps");
        push(2, 255,  16'hFFFF, 1'b0, "restart_pre");
        push(2, 256,  16'hFFFF, 1'b1, "restart_ps");
        rst_off();
        wait_cyc(1025);

        // Static outputs, enable change mid-period, one-clock latency
        rst_on();
        en_out = 16'h0000;
        en_pwm = 16'h0000;
        duty   = 8'h80;
        push(0, 0,    16'h0000, 1'b0, "static_rst");
        push(0, 10,   16'h0000, 1'b0, "static_pre");
        push(0, 11,   16'h00FF, 1'b0, "static_lat");
        push(0, 1024, 16'h00FF, 1'b1, "static_p1");
        push(0, 2048, 16'h00FF, 1'b1, "static_p2");
        push(0, 3000, 16'h00FF, 1'b0, "static_mid");
        push(0, 3072, 16'h00FF, 1'b1, "static_p3");
        rst_off();
        wait_cyc(10);
        en_out = 16'h00FF;
        wait_cyc(3073);

        // 50% duty on every channel
        rst_on();
        en_out = 16'hFFFF;
        en_pwm = 16'hFFFF;
        duty   = 8'h80;
        push(0, 1024, 16'h0000, 1'b1, "d50_ps");
        push(0, 1025, 16'hFFFF, 1'b0, "d50_rise");
        push(0, 1536, 16'hFFFF, 1'b0, "d50_lasthi");
        push(0, 1537, 16'h0000, 1'b0, "d50_fall");
        push(0, 2047, 16'h0000, 1'b0, "d50_lastlo");
        push(0, 2048, 16'h0000, 1'b1, "d50_ps2");
        push(0, 2049, 16'hFFFF, 1'b0, "d50_rise2");
        push(1, 512,  16'h0000, 1'b1, "d50_ps");
        push(1, 513,  16'hFFFF, 1'b0, "d50_rise");
        push(1, 768,  16'hFFFF, 1'b0, "d50_lasthi");
        push(1, 769,  16'h0000, 1'b0, "d50_fall");
        push(1, 1024, 16'h0000, 1'b1, "d50_ps2");
        push(2, 256,  16'h0000, 1'b1, "d50_ps");
        push(2, 257,  16'hFFFF, 1'b0, "d50_rise");
        push(2, 384,  16'hFFFF, 1'b0, "d50_lasthi");
        push(2, 385,  16'h0000, 1'b0, "d50_fall");
        push(2, 512,  16'h0000, 1'b1, "d50_ps2");
        rst_off();
        wait_cyc(2050);

        // Duty 0x00: PWM channels never high
        rst_on();
        duty = 8'h00;
        push(0, 1025, 16'h0000, 1'b0, "d0_start");
        push(0, 1500, 16'h0000, 1'b0, "d0_mid");
        push(0, 2048, 16'h0000, 1'b1, "d0_ps");
        rst_off();
        wait_cyc(2050);

        // Duty 0xFF: solid high, including counter value 255
        rst_on();
        duty = 8'hFF;
        push(0, 1025, 16'hFFFF, 1'b0, "dff_start");
        push(0, 1600, 16'hFFFF, 1'b0, "dff_mid");
        push(0, 2048, 16'hFFFF, 1'b1, "dff_cnt255");
        push(0, 2049, 16'hFFFF, 1'b0, "dff_next");
        rst_off();
        wait_cyc(2050);

        // Duty 0x01: high for exactly CLK_DIV clocks per period
        rst_on();
        duty = 8'h01;
        push(0, 1024, 16'h0000, 1'b1, "d1_ps");
        push(0, 1025, 16'hFFFF, 1'b0, "d1_first");
        push(0, 1028, 16'hFFFF, 1'b0, "d1_last");
        push(0, 1029, 16'h0000, 1'b0, "d1_fall");
        push(0, 2048, 16'h0000, 1'b1, "d1_ps2");
        push(0, 2049, 16'hFFFF, 1'b0, "d1_rise2");
        push(2, 256,  16'h0000, 1'b1, "d1_ps");
        push(2, 257,  16'hFFFF, 1'b0, "d1_single");
        push(2, 258,  16'h0000, 1'b0, "d1_fall");
        rst_off();
        wait_cyc(2050);

        // Mixed modes at 25% duty, CLK_DIV=2
        rst_on();
        en_out = 16'hA5A5;
        en_pwm = 16'h0F0F;
        duty   = 8'h40;
        push(1, 512,  16'hA0A0, 1'b1, "mix_ps");
        push(1, 513,  16'hA5A5, 1'b0, "mix_rise");
        push(1, 640,  16'hA5A5, 1'b0, "mix_lasthi");
        push(1, 641,  16'hA0A0, 1'b0, "mix_fall");
        push(1, 1024, 16'hA0A0, 1'b1, "mix_ps2");
        push(1, 1025, 16'hA5A5, 1'b0, "mix_rise2");
        rst_off();
        wait_cyc(1026);

        // Duty 0x40 -> 0xC0 written while the counter reads 0x20
        rst_on();
        en_out = 16'hFFFF;
        en_pwm = 16'hFFFF;
        duty   = 8'h40;
        push(0, 1100, 16'hFFFF, 1'b0, "upd_before");
        push(0, 1280, 16'hFFFF, 1'b0, "upd_step3f");
`ifdef PWM_SHADOW_EN
        push(0, 1281, 16'h0000, 1'b0, "upd_step40");
        push(0, 1792, 16'h0000, 1'b0, "upd_stepbf");
`else
        push(0, 1281, 16'hFFFF, 1'b0, "upd_step40");
        push(0, 1792, 16'hFFFF, 1'b0, "upd_stepbf");
`endif
        push(0, 1793, 16'h0000, 1'b0, "upd_stepc0");
        push(0, 2048, 16'h0000, 1'b1, "upd_ps");
        push(0, 2049, 16'hFFFF, 1'b0, "upd_rise");
        push(0, 2816, 16'hFFFF, 1'b0, "upd_lasthi");
        push(0, 2817, 16'h0000, 1'b0, "upd_fall");
        rst_off();
        wait_cyc(1152);
        duty = 8'hC0;
        wait_cyc(2818);

        if (n_fail == 0)
            $display("PASS: %0d assertions evaluated", n_assert);
        else
            $display("FAIL: %0d of %0d assertions failed", n_fail, n_assert);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
